// File: rtl/vec_pkg.sv
//==============================================================================
// Module  : vec_pkg
// Brief   : Shared types, constants and the per-component scaling function
//           for the vec_scale_arb shared vector-scaling unit.
//           Build option: VEC_SCALE_FIXED_EN selects signed Q16.16 arithmetic;
//           when undefined, the unit does wrapping 32-bit integer multiply.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package vec_pkg;

    localparam int COMP_W = 32;
    localparam int VEC_W  = 96;
    localparam int FRAC_W = 16;

    typedef logic [COMP_W-1:0] scalar_t;

    // x occupies the most significant slot so that {x,y,z} packs naturally
    typedef struct packed {
        scalar_t x;
        scalar_t y;
        scalar_t z;
    } vec3_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_X = 3'd1,
        ST_MUL_Y = 3'd2,
        ST_MUL_Z = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One component times the scalar. Called from a single site in the top
    // so that exactly one multiplier is built.
    function automatic scalar_t scale_comp(input scalar_t op, input scalar_t scale);
`ifdef VEC_SCALE_FIXED_EN
        logic signed [2*COMP_W-1:0] prod;
        // Signed Q16.16 product; the arithmetic shift floors toward -inf
        prod = $signed(op) * $signed(scale);
        return scalar_t'(prod >>> FRAC_W);
`else
        // Integer mode: keep the low word, wrapping modulo 2^32
        return op * scale;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker. Grants the first asserted
//           request at or after ptr_i, wrapping modulo NREQ. The pointer
//           itself is owned by the instantiating block.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int ID_W = $clog2(NREQ);

    // Scan NREQ positions starting at the pointer; the first hit wins
    always_comb begin
        int k;
        k       = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!any_o && req_i[k]) begin
                any_o      = 1'b1;
                idx_o      = k[ID_W-1:0];
                grant_o[k] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vec_scale_arb.sv
//==============================================================================
// Module  : vec_scale_arb
// Brief   : Shared vector-scaling unit. A round-robin arbiter accepts one
//           {x,y,z} vector plus scalar from up to NREQ requesters; a small FSM
//           pushes x, y and z through one shared multiplier over three cycles
//           and returns the scaled vector with the owner's id on a
//           valid/ready port.
//           Build option: VEC_SCALE_FIXED_EN selects signed Q16.16 arithmetic
//           (see vec_pkg::scale_comp); integer mode otherwise.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module vec_scale_arb
    import vec_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*VEC_W-1:0]   req_vec,
    input  logic [NREQ*COMP_W-1:0]  req_scale,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VEC_W-1:0]        out_vec,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                    busy
);

    localparam int ID_W = $clog2(NREQ);
    localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(NREQ - 1);

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    logic [ID_W-1:0] out_id_q;
    vec3_t           op_q;
    scalar_t         scale_q;
    vec3_t           out_vec_q;
    logic            out_valid_q;
    logic            busy_q;

    vec3_t           req_vec_arr   [NREQ];
    scalar_t         req_scale_arr [NREQ];

    logic [NREQ-1:0] arb_grant;
    logic [ID_W-1:0] arb_idx;
    logic            arb_any;

    scalar_t         mul_op;
    scalar_t         mul_res;

    // Split the flat request buses into per-requester lanes
    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign req_vec_arr[k]   = req_vec[k*VEC_W +: VEC_W];
        assign req_scale_arr[k] = req_scale[k*COMP_W +: COMP_W];
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Pointer moves to the slot just after the winner so it has lowest priority next
    assign rr_ptr_d = (arb_idx == C_LAST_ID) ? '0 : arb_idx + ID_W'(1);

    // Accept only while idle; reset also forces the handshake low
    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? arb_grant : '0;

    // Component mux in front of the single shared multiplier
    always_comb begin
        mul_op = op_q.z;
        case (state_q)
            ST_MUL_X: mul_op = op_q.x;
            ST_MUL_Y: mul_op = op_q.y;
            default:  mul_op = op_q.z;
        endcase
    end

    assign mul_res = scale_comp(mul_op, scale_q);

    // Control FSM: grant, three multiply steps, then hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            out_id_q    <= '0;
            op_q        <= '0;
            scale_q     <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        op_q     <= req_vec_arr[arb_idx];
                        scale_q  <= req_scale_arr[arb_idx];
                        out_id_q <= arb_idx;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= ST_MUL_X;
                    end
                end
                ST_MUL_X: begin
                    out_vec_q.x <= mul_res;
                    state_q     <= ST_MUL_Y;
                end
                ST_MUL_Y: begin
                    out_vec_q.y <= mul_res;
                    state_q     <= ST_MUL_Z;
                end
                ST_MUL_Z: begin
                    out_vec_q.z <= mul_res;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign out_id    = out_id_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_scale_arb.sv
//==============================================================================
// Module  : tb_vec_scale_arb
// Brief   : Self-checking bench for vec_scale_arb with a transaction-level
//           reference model. Honours VEC_SCALE_FIXED_EN for expected values.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vec_scale_arb;

    localparam int NREQ = 3;
    localparam int ID_W = $clog2(NREQ);

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*96-1:0]    req_vec;
    logic [NREQ*32-1:0]    req_scale;
    logic                  out_valid;
    logic                  out_ready;
    logic [95:0]           out_vec;
    logic [ID_W-1:0]       out_id;
    logic                  busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          inflight;
    int          cnt;
    int          ptr;
    int          exp_id;
    logic [95:0] exp_vec;
    logic [95:0] last_vec;
    int          last_id;
    int          cyc;
    int          grants[$];
    int          grant_cyc[$];

    vec_scale_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vec   (req_vec),
        .req_scale (req_scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Mathematical definition of one scaled component
    function automatic logic [31:0] ref_scale(input logic [31:0] a, input logic [31:0] b);
`ifdef VEC_SCALE_FIXED_EN
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        p = p >>> 16;
        return p[31:0];
`else
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[31:0];
`endif
    endfunction

    task automatic set_req(input int k, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [31:0] s);
        req_vec[k*96 +: 96]   = {x, y, z};
        req_scale[k*32 +: 32] = s;
        req_valid[k]          = 1'b1;
    endtask

    task automatic rand_req(input int k);
        set_req(k, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_vec",   out_vec,   0);
        check_val("rst_out_id",    out_id,    0);
        check_val("rst_busy",      busy,      0);
    endtask

    // One clock: evaluate the model against the DUT on the falling edge,
    // then let the rising edge happen and retire the granted request.
    task automatic cycle();
        logic [NREQ-1:0] exp_rdy;
        int g;
        @(negedge clk);
        cyc++;
        exp_rdy = '0;
        g = -1;
        if (!inflight) begin
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (ptr + i) % NREQ;
                if (g < 0 && req_valid[k]) g = k;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check_val("req_ready", req_ready, exp_rdy);
            check_val("busy_idle", busy, 0);
            check_val("out_valid_idle", out_valid, 0);
            if (g >= 0) begin
                inflight = 1'b1;
                cnt      = 0;
                exp_id   = g;
                exp_vec  = {ref_scale(req_vec[g*96+64 +: 32], req_scale[g*32 +: 32]),
                            ref_scale(req_vec[g*96+32 +: 32], req_scale[g*32 +: 32]),
                            ref_scale(req_vec[g*96    +: 32], req_scale[g*32 +: 32])};
                ptr      = (g + 1) % NREQ;
                grants.push_back(g);
                grant_cyc.push_back(cyc);
            end
        end else begin
            cnt++;
            check_val("req_ready_busy", req_ready, 0);
            check_val("busy", busy, 1);
            check_val("out_valid", out_valid, (cnt >= 4) ? 1 : 0);
            if (cnt >= 4) begin
                check_val("out_vec", out_vec, exp_vec);
                check_val("out_id", out_id, exp_id);
                if (out_ready) begin
                    inflight = 1'b0;
                    last_vec = exp_vec;
                    last_id  = exp_id;
                end
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic run_until_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle();
            if (!inflight && !(|req_valid)) done = 1'b1;
        end
        check_val("idle_timeout", done, 1);
    endtask

    task automatic drain();
        req_valid = '0;
        out_ready = 1'b1;
        run_until_idle();
    endtask

    initial begin
        int exp_order[6];
        int base;
        bit hit;
        exp_order = '{0, 1, 2, 0, 1, 2};

        rst_n     = 1'b0;
        req_valid = '0;
        req_vec   = '0;
        req_scale = '0;
        out_ready = 1'b1;
        inflight  = 1'b0;
        cnt       = 0;
        ptr       = 0;
        cyc       = 0;
        last_vec  = '0;
        last_id   = 0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();

        // Fairness: all requesters valid continuously from reset
        for (int k = 0; k < NREQ; k++) rand_req(k);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cycle();
            for (int k = 0; k < NREQ; k++) if (!req_valid[k]) rand_req(k);
        end
        check_val("fair_count_ok", grants.size() >= 6, 1);
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            check_val($sformatf("fair_order%0d", i), grants[i], exp_order[i]);
            if (i > 0) check_val($sformatf("fair_gap%0d", i), grant_cyc[i] - grant_cyc[i-1], 5);
        end
        drain();

        // Single request, directed values
        set_req(0, 32'd2, 32'd3, 32'd4, 32'd5);
        run_until_idle();
        check_val("single_id", last_id, 0);
`ifndef VEC_SCALE_FIXED_EN
        check_val("single_vec", last_vec, {32'd10, 32'd15, 32'd20});
        // Wrap-around in integer mode
        set_req(0, 32'hFFFFFFFF, 32'h80000000, 32'd7, 32'd2);
        run_until_idle();
        check_val("wrap_vec", last_vec, {32'hFFFFFFFE, 32'h00000000, 32'd14});
`else
        set_req(0, 32'h00018000, 32'hFFFF0000, 32'h0, 32'h00020000);
        run_until_idle();
        check_val("fixed_vec", last_vec, {32'h00030000, 32'hFFFE0000, 32'h0});
        set_req(0, 32'hFFFF0000, 32'h0, 32'h0, 32'h00008000);
        run_until_idle();
        check_val("fixed_neg_x", last_vec[95:64], 32'hFFFF8000);
`endif

        // Backpressure in DONE, with a competing request that must not be granted
        out_ready = 1'b0;
        rand_req(1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            if (inflight && cnt >= 4) hit = 1'b1;
        end
        check_val("bp_reach_done", hit, 1);
        rand_req(2);
        repeat (10) cycle();
        out_ready = 1'b1;
        run_until_idle();

        // Asynchronous reset in the middle of an op
        drain();
        rand_req(0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            if (inflight && cnt == 1) hit = 1'b1;
        end
        check_val("midop_reach_mul_y", hit, 1);
        rand_req(0);
        rand_req(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        inflight = 1'b0;
        ptr      = 0;
        base     = grants.size();
        #2;
        rst_n = 1'b1;
        run_until_idle();
        check_val("post_rst_grants", grants.size() >= base + 2, 1);
        if (grants.size() > base) check_val("post_rst_first", grants[base], 0);

        // Randomized traffic with random backpressure and early drops
        for (int i = 0; i < 600; i++) begin
            cycle();
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k]) begin
                    if ($urandom_range(0, 2) == 0) rand_req(k);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
